// File: rtl/window_gen_3x3.sv
// Raster RGB332 stream to a registered 3x3 neighbourhood (two line buffers plus a 3x3 shift window).
// Optional define WIN_COORD_EN adds the win_cx/win_cy window-centre coordinate outputs.
module window_gen_3x3 #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic [PIX_W-1:0] a0,
   output logic [PIX_W-1:0] a1,
   output logic [PIX_W-1:0] a2,
   output logic [PIX_W-1:0] a7,
   output logic [PIX_W-1:0] pix,
   output logic [PIX_W-1:0] a3,
   output logic [PIX_W-1:0] a6,
   output logic [PIX_W-1:0] a5,
   output logic [PIX_W-1:0] a4,
`ifdef WIN_COORD_EN
   output logic [$clog2(IMG_W)-1:0] win_cx,
   output logic [$clog2(IMG_H)-1:0] win_cy,
`endif
   output logic             win_valid
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_TWO  = XW'(2);
   localparam logic [YW-1:0] Y_TWO  = YW'(2);

   logic [XW-1:0]    x_q, x_d, cur_x;
   logic [YW-1:0]    y_q, y_d, cur_y;
   logic             vld_q, vld_d;
   logic [PIX_W-1:0] lb0_q [IMG_W];
   logic [PIX_W-1:0] lb1_q [IMG_W];
   logic [PIX_W-1:0] t, m;
   logic [PIX_W-1:0] top_q [3];
   logic [PIX_W-1:0] mid_q [3];
   logic [PIX_W-1:0] bot_q [3];

   // sof overrides the counters so the accepted pixel becomes (0,0) on the same edge
   always_comb begin
      cur_x = sof ? '0 : x_q;
      cur_y = sof ? '0 : y_q;
      t     = lb1_q[cur_x];
      m     = lb0_q[cur_x];
      x_d   = x_q;
      y_d   = y_q;
      vld_d = 1'b0;
      if (pix_valid) begin
         vld_d = (cur_x >= X_TWO) && (cur_y >= Y_TWO);
         if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
         end else begin
            x_d = cur_x + XW'(1);
            y_d = cur_y;
         end
      end
   end

   // line buffers carry no reset; rows 0 and 1 of every frame refill them before any window is shown
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb1_q[cur_x] <= m;
         lb0_q[cur_x] <= pix_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q   <= '0;
         y_q   <= '0;
         vld_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            top_q[i] <= '0;
            mid_q[i] <= '0;
            bot_q[i] <= '0;
         end
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         vld_q <= vld_d;
         if (pix_valid) begin
            for (int i = 0; i < 2; i++) begin
               top_q[i] <= top_q[i+1];
               mid_q[i] <= mid_q[i+1];
               bot_q[i] <= bot_q[i+1];
            end
            top_q[2] <= t;
            mid_q[2] <= m;
            bot_q[2] <= pix_in;
         end
      end
   end

`ifdef WIN_COORD_EN
   logic [XW-1:0] cx_q;
   logic [YW-1:0] cy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cx_q <= '0;
         cy_q <= '0;
      end else if (pix_valid) begin
         cx_q <= cur_x - XW'(1);
         cy_q <= cur_y - YW'(1);
      end
   end

   assign win_cx = cx_q;
   assign win_cy = cy_q;
`endif

   assign a0        = top_q[0];
   assign a1        = top_q[1];
   assign a2        = top_q[2];
   assign a7        = mid_q[0];
   assign pix       = mid_q[1];
   assign a3        = mid_q[2];
   assign a6        = bot_q[0];
   assign a5        = bot_q[1];
   assign a4        = bot_q[2];
   assign win_valid = vld_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on an 8x6 image; the reference keeps the frame as a 2-D pixel array.
// Coordinate outputs are checked when WIN_COORD_EN is defined.
module tb_window_gen_3x3;
   localparam int W = 8;
   localparam int H = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] pix_in = '0;
   logic       pix_valid = 1'b0;
   logic       sof = 1'b0;
   logic [7:0] a0, a1, a2, a7, pix, a3, a6, a5, a4;
   logic       win_valid;
`ifdef WIN_COORD_EN
   logic [2:0] win_cx;
   logic [2:0] win_cy;
`endif

   always #5 clk = ~clk;

   window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .a0(a0), .a1(a1), .a2(a2), .a7(a7), .pix(pix), .a3(a3), .a6(a6), .a5(a5), .a4(a4),
`ifdef WIN_COORD_EN
      .win_cx(win_cx), .win_cy(win_cy),
`endif
      .win_valid(win_valid)
   );

   wire [71:0] obs_win = {a0, a1, a2, a7, pix, a3, a6, a5, a4};

   int n_checks = 0;
   int n_fail = 0;

   // reference: image as written so far, raster position, expected window
   logic [7:0]  img [H][W];
   int          mx = 0, my = 0, lx = 0, ly = 0, exp_cx = 0, exp_cy = 0;
   bit          exp_vld = 1'b0;
   bit          win_known = 1'b1;
   logic [71:0] exp_win = '0;

   task automatic drive(input bit v, input bit s, input logic [7:0] d);
      int cx, cy;
      pix_valid = v;
      sof       = s;
      pix_in    = d;
      exp_vld   = 1'b0;
      if (v) begin
         cx = s ? 0 : mx;
         cy = s ? 0 : my;
         img[cy][cx] = d;
         lx = cx;
         ly = cy;
         if (cx >= 2 && cy >= 2) begin
            exp_vld   = 1'b1;
            win_known = 1'b1;
            exp_win = {img[cy-2][cx-2], img[cy-2][cx-1], img[cy-2][cx],
                       img[cy-1][cx-2], img[cy-1][cx-1], img[cy-1][cx],
                       img[cy][cx-2],   img[cy][cx-1],   img[cy][cx]};
            exp_cx = cx - 1;
            exp_cy = cy - 1;
         end else begin
            win_known = 1'b0;
         end
         if (cx == W - 1) begin
            mx = 0;
            my = (cy + 1) % H;
         end else begin
            mx = cx + 1;
            my = cy;
         end
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (win_valid !== 1'b0 || obs_win !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_hold: win_valid=%b win=%h, want 0 and all zero", win_valid, obs_win);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) begin
         drive(1'b0, 1'b1, 8'hFF);
         n_checks++;
         if (win_valid !== 1'b0 || obs_win !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_release: win_valid=%b win=%h, want 0 and all zero", win_valid, obs_win);
         end
      end
   endtask

   task automatic test_basic_frame();
      int pulses = 0;
      bit first = 1'b1;
      logic [7:0] last_pix = '0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            drive(1'b1, (x == 0 && y == 0), 8'(y * 16 + x));
            n_checks++;
            if (win_valid !== exp_vld) begin
               n_fail++;
               $display("FAIL basic_vld at (%0d,%0d): got %b want %b", lx, ly, win_valid, exp_vld);
            end
            if (win_valid === 1'b1) begin
               pulses++;
               last_pix = pix;
            end
            if (exp_vld) begin
               n_checks++;
               if (obs_win !== exp_win) begin
                  n_fail++;
                  $display("FAIL basic_win at (%0d,%0d): got %h want %h", lx, ly, obs_win, exp_win);
               end
               if (first) begin
                  first = 1'b0;
                  n_checks++;
                  if (obs_win !== 72'h00_01_02_10_11_12_20_21_22) begin
                     n_fail++;
                     $display("FAIL basic_first: got %h want 000102101112202122", obs_win);
                  end
               end
            end
         end
      end
      n_checks++;
      if (pulses != (W - 2) * (H - 2)) begin
         n_fail++;
         $display("FAIL basic_count: got %0d want %0d", pulses, (W - 2) * (H - 2));
      end
      n_checks++;
      if (last_pix !== 8'h46) begin
         n_fail++;
         $display("FAIL basic_last_pix: got %h want 46", last_pix);
      end
   endtask

   task automatic test_gapped();
      int pulses = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            repeat ($urandom_range(3, 0)) begin
               drive(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
               n_checks++;
               if (win_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL gap_vld: got %b want 0", win_valid);
               end
               if (win_known) begin
                  n_checks++;
                  if (obs_win !== exp_win) begin
                     n_fail++;
                     $display("FAIL gap_hold: got %h want %h", obs_win, exp_win);
                  end
               end
            end
            drive(1'b1, (x == 0 && y == 0), 8'(y * 16 + x));
            n_checks++;
            if (win_valid !== exp_vld) begin
               n_fail++;
               $display("FAIL gapped_vld at (%0d,%0d): got %b want %b", lx, ly, win_valid, exp_vld);
            end
            if (win_valid === 1'b1) pulses++;
            if (exp_vld) begin
               n_checks++;
               if (obs_win !== exp_win) begin
                  n_fail++;
                  $display("FAIL gapped_win at (%0d,%0d): got %h want %h", lx, ly, obs_win, exp_win);
               end
            end
         end
      end
      n_checks++;
      if (pulses != (W - 2) * (H - 2)) begin
         n_fail++;
         $display("FAIL gapped_count: got %0d want %0d", pulses, (W - 2) * (H - 2));
      end
   endtask

   task automatic test_early_sof();
      int pulses = 0;
      bit first = 1'b1;
      drive(1'b1, 1'b1, 8'($urandom));
      while (!(mx == 5 && my == 3)) begin
         drive(1'b1, 1'b0, 8'($urandom));
         n_checks++;
         if (win_valid !== exp_vld || (exp_vld && obs_win !== exp_win)) begin
            n_fail++;
            $display("FAIL presof_win at (%0d,%0d): vld %b win %h, want vld %b win %h",
                     lx, ly, win_valid, obs_win, exp_vld, exp_win);
         end
      end
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            drive(1'b1, (x == 0 && y == 0), 8'(y * 16 + x));
            n_checks++;
            if (win_valid !== exp_vld) begin
               n_fail++;
               $display("FAIL sof_vld at (%0d,%0d): got %b want %b", lx, ly, win_valid, exp_vld);
            end
            if (win_valid === 1'b1) pulses++;
            if (exp_vld) begin
               n_checks++;
               if (obs_win !== exp_win) begin
                  n_fail++;
                  $display("FAIL sof_win at (%0d,%0d): got %h want %h", lx, ly, obs_win, exp_win);
               end
               if (first) begin
                  first = 1'b0;
                  n_checks++;
                  if (pix !== 8'h11) begin
                     n_fail++;
                     $display("FAIL sof_first_pix: got %h want 11", pix);
                  end
               end
            end
         end
      end
      n_checks++;
      if (pulses != (W - 2) * (H - 2)) begin
         n_fail++;
         $display("FAIL sof_count: got %0d want %0d", pulses, (W - 2) * (H - 2));
      end
   endtask

   task automatic test_async_reset();
      int pulses = 0;
      drive(1'b1, 1'b1, 8'($urandom));
      while (!(mx == 4 && my == 3)) begin
         drive(1'b1, 1'b0, 8'($urandom));
         n_checks++;
         if (win_valid !== exp_vld || (exp_vld && obs_win !== exp_win)) begin
            n_fail++;
            $display("FAIL prerst_win at (%0d,%0d): vld %b win %h, want vld %b win %h",
                     lx, ly, win_valid, obs_win, exp_vld, exp_win);
         end
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (win_valid !== 1'b0 || obs_win !== 72'h0) begin
         n_fail++;
         $display("FAIL async_rst: win_valid=%b win=%h, want 0 and all zero", win_valid, obs_win);
      end
`ifdef WIN_COORD_EN
      n_checks++;
      if (win_cx !== 3'd0 || win_cy !== 3'd0) begin
         n_fail++;
         $display("FAIL async_rst_coord: got (%0d,%0d) want (0,0)", win_cx, win_cy);
      end
`endif
      mx = 0;
      my = 0;
      exp_win = '0;
      win_known = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            n_checks++;
            if (win_valid !== exp_vld) begin
               n_fail++;
               $display("FAIL postrst_vld at (%0d,%0d): got %b want %b", lx, ly, win_valid, exp_vld);
            end
            if (win_valid === 1'b1) pulses++;
            if (exp_vld) begin
               n_checks++;
               if (obs_win !== exp_win) begin
                  n_fail++;
                  $display("FAIL postrst_win at (%0d,%0d): got %h want %h", lx, ly, obs_win, exp_win);
               end
            end
         end
      end
      n_checks++;
      if (pulses != (W - 2) * (H - 2)) begin
         n_fail++;
         $display("FAIL postrst_count: got %0d want %0d", pulses, (W - 2) * (H - 2));
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 2; f++) begin
         int pulses = 0;
         for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
               drive(1'b1, (x == 0 && y == 0), 8'($urandom));
               n_checks++;
               if (win_valid !== exp_vld) begin
                  n_fail++;
                  $display("FAIL b2b_vld f%0d (%0d,%0d): got %b want %b", f, lx, ly, win_valid, exp_vld);
               end
               if (win_valid === 1'b1) pulses++;
               if (exp_vld) begin
                  n_checks++;
                  if (obs_win !== exp_win) begin
                     n_fail++;
                     $display("FAIL b2b_win f%0d (%0d,%0d): got %h want %h", f, lx, ly, obs_win, exp_win);
                  end
`ifdef WIN_COORD_EN
                  n_checks++;
                  if (win_cx !== 3'(exp_cx) || win_cy !== 3'(exp_cy)) begin
                     n_fail++;
                     $display("FAIL b2b_coord: got (%0d,%0d) want (%0d,%0d)", win_cx, win_cy, exp_cx, exp_cy);
                  end
                  if (lx == 2 && ly == 2) begin
                     n_checks++;
                     if (win_cx !== 3'd1 || win_cy !== 3'd1) begin
                        n_fail++;
                        $display("FAIL b2b_first_coord: got (%0d,%0d) want (1,1)", win_cx, win_cy);
                     end
                  end
                  if (lx == W - 1 && ly == H - 1) begin
                     n_checks++;
                     if (win_cx !== 3'd6 || win_cy !== 3'd4) begin
                        n_fail++;
                        $display("FAIL b2b_last_coord: got (%0d,%0d) want (6,4)", win_cx, win_cy);
                     end
                  end
`endif
               end
            end
         end
         n_checks++;
         if (pulses != (W - 2) * (H - 2)) begin
            n_fail++;
            $display("FAIL b2b_count f%0d: got %0d want %0d", f, pulses, (W - 2) * (H - 2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_gapped();
      test_early_sof();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Upstream neighbour of the 3x3 Gaussian blur stage.
- Accepts a raster-order stream of RGB332 pixels and keeps two line buffers plus a 3x3 shift window.
- Presents each full interior 3x3 neighbourhood on nine registered 8-bit outputs.
- Downstream splits each output into r[7:5], g[4:2], b[1:0] for the blur's per-channel inputs.

Parameters:
- IMG_W, 640, active pixels per line; must be ≥3.
- IMG_H, 480, active lines per frame; must be ≥3.
- PIX_W, 8, pixel width in bits (RGB332).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low: asserted when 0, released when 1.
- pix_in  input  PIX_W  incoming pixel.
- pix_valid  input  1  pix_in is accepted on this edge.
- sof  input  1  start of frame; qualified by pix_valid; marks the current pixel as (0,0).
- a0,a1,a2  output  PIX_W  top row of the window: left, middle, right.
- a7,pix,a3  output  PIX_W  middle row of the window: left, centre, right.
- a6,a5,a4  output  PIX_W  bottom row of the window: left, middle, right.
- win_valid  output  1  one-cycle strobe: window outputs hold a new full window.

Behaviour:
- Counters: col x in 0..IMG_W-1, row y in 0..IMG_H-1. Counter widths are $clog2 of the dimension.
- Coordinate of the accepted pixel: if sof=1, it is (0,0); otherwise it is the current (x,y).
- After acceptance, counters advance to the next coordinate in raster order. After (IMG_W-1,IMG_H-1) they wrap to (0,0).
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2. Each is IMG_W x PIX_W with asynchronous read.
- On an accepted pixel at column x:
  - read t=lb1[x] and m=lb0[x];
  - write lb1[x]<=m and lb0[x]<=pix_in.
- Window register: 3 columns x 3 rows.
  - On an accepted pixel, the columns shift left.
  - The new right column is {top=t, mid=m, bottom=pix_in}.
- Output mapping:
  - top row (row y-2): a0 at col x-2, a1 at col x-1, a2 at col x.
  - middle row (row y-1): a7 at col x-2, pix at col x-1, a3 at col x.
  - bottom row (row y): a6 at col x-2, a5 at col x-1, a4 at col x.
  - The window is therefore centred on (x-1, y-1).
- Latency: outputs and win_valid update on the edge that accepts the pixel and are visible the following cycle.
  - win_valid=1 for exactly one cycle after an accepted pixel at x≥2 and y≥2.
  - Otherwise win_valid=0.
- Emitted centres cover 1..IMG_W-2 by 1..IMG_H-2, giving (IMG_W-2)*(IMG_H-2) windows per frame. Border pixels produce no window.
- pix_valid=0: counters, buffers and window hold; win_valid=0 the next cycle.
- sof at any column or row resynchronises the counters immediately.
  - Rows 0 and 1 of the new frame never produce win_valid.
  - Stale line-buffer data is therefore never exposed.
- sof with pix_valid=0 is ignored.
- Reset (rst=0, asynchronous):
  - window registers go to 0x00, so all nine outputs are 0x00;
  - win_valid=0 and x=y=0.
  - Line buffers are not cleared.
  - After release, the first accepted pixel is treated as (0,0) with or without sof.
- Reset mid-frame aborts the frame. No window is emitted until row 2 of the next counted frame.

Optional Feature:
- Macro WIN_COORD_EN.
- When defined, adds outputs win_cx [$clog2(IMG_W)-1:0] and win_cy [$clog2(IMG_H)-1:0].
  - They are registered alongside the window and equal to the centre coordinate (x-1, y-1).
  - Reset value is 0; they hold when no pixel is accepted.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 and toggle clk → all nine outputs are 0x00 and win_valid=0. Release rst → still 0 until the first valid pixel.
- Basic frame, IMG_W=8, IMG_H=6, pix_in=y*16+x, continuous pix_valid, sof on (0,0):
  - first win_valid appears one cycle after pixel (2,2);
  - a0=00, a1=01, a2=02, a3=12, a4=22, a5=21, a6=20, a7=10, pix=11;
  - exactly 24 win_valid pulses per frame;
  - last window has pix=0x46.
- Gapped input: same frame with 0–3 random idle cycles between pixels → identical window sequence, win_valid never asserted during gaps, outputs hold their values.
- Early sof: assert sof with the pixel at (5,3) → counters restart, no win_valid until the new frame's (2,2), and the first window centre pix=0x11 per the new frame's values.
- Async reset mid-frame: drive rst=0 between clock edges at row 3 → win_valid and all outputs go to 0 without waiting for a clock edge. The next frame, started without sof, is windowed correctly.
- WIN_COORD_EN defined, back-to-back frames:
  - first window has win_cx=1, win_cy=1; last window has win_cx=6, win_cy=4;
  - frame 2's first window contains only frame-2 pixels.
